// File: rtl/trig_capture_ctrl.sv
// Capture sequencer: arms the sample RAM, fills the pre-trigger window, accepts
// the first enabled trigger (force > ch > uart > spi), counts post samples, flags done.
// Latency: we_o is combinational from smpl_en_i; state and flag outputs update one cycle after the deciding edge.
// Backpressure: none. Every smpl_en_i strobe in PRETRIG/ARMED/POST is written.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   arm_i, clr_done_i          command pulses: start capture / abort-or-acknowledge
//   smpl_en_i                  sample strobe from the decimator
//   trig_pos_i, trig_en_i      post-trigger sample count and {spi,uart,ch} enables, latched on arm
//   ch/uart/spi/force_trig_i   trigger pulses
//   we_o, waddr_o              sample RAM write port
//   armed_o, triggered_o, capture_done_o   status flags
//   trig_addr_o, trig_src_o    write address and source of the accepted trigger
module trig_capture_ctrl #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm_i,
  input  logic          clr_done_i,
  input  logic          smpl_en_i,
  input  logic [AW-1:0] trig_pos_i,
  input  logic [2:0]    trig_en_i,
  input  logic          ch_trig_i,
  input  logic          uart_trig_i,
  input  logic          spi_trig_i,
  input  logic          force_trig_i,
  output logic          we_o,
  output logic [AW-1:0] waddr_o,
  output logic          armed_o,
  output logic          triggered_o,
  output logic          capture_done_o,
  output logic [AW-1:0] trig_addr_o,
  output logic [1:0]    trig_src_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRETRIG,
    S_ARMED,
    S_POST,
    S_DONE
  } state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW:0]   cnt_q, cnt_d;          // shared pre-trigger / post-trigger counter
  logic [AW-1:0] pos_q, pos_d;
  logic [2:0]    en_q, en_d;
  logic [AW-1:0] taddr_q, taddr_d;
  logic [1:0]    tsrc_q, tsrc_d;

  logic          we;
  logic          hit;
  logic [1:0]    hit_src;
  logic [AW:0]   cnt_inc;
  logic [AW:0]   pre_thresh;
  logic [AW:0]   pos_ext;

  assign pos_ext    = {1'b0, pos_q};
  assign cnt_inc    = cnt_q + ONE_C;
  // Pre-trigger window plus post window fills exactly DEPTH entries.
  assign pre_thresh = DEPTH_C - pos_ext;

  assign hit = force_trig_i | (ch_trig_i & en_q[0]) |
               (uart_trig_i & en_q[1]) | (spi_trig_i & en_q[2]);

  always_comb begin
    hit_src = 2'd3;
    if (force_trig_i)                hit_src = 2'd0;
    else if (ch_trig_i & en_q[0])    hit_src = 2'd1;
    else if (uart_trig_i & en_q[1])  hit_src = 2'd2;
  end

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    en_d    = en_q;
    taddr_d = taddr_q;
    tsrc_d  = tsrc_q;
    we      = 1'b0;

    if (clr_done_i) begin
      // Abort/acknowledge beats everything, including a same-cycle arm or hit.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm_i) begin
            state_d = S_PRETRIG;
            waddr_d = '0;
            cnt_d   = '0;
            pos_d   = trig_pos_i;
            en_d    = trig_en_i;
          end
        end
        S_PRETRIG: begin
          we = smpl_en_i;
          if (smpl_en_i) begin
            cnt_d = cnt_inc;
            if (cnt_inc == pre_thresh) state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          we = smpl_en_i;
          if (hit) begin
            taddr_d = waddr_q;
            tsrc_d  = hit_src;
            // A strobe on the accept cycle is already post sample #1.
            cnt_d   = smpl_en_i ? ONE_C : '0;
            if ((pos_q == '0) || (smpl_en_i && (pos_ext == ONE_C)))
              state_d = S_DONE;
            else
              state_d = S_POST;
          end
        end
        S_POST: begin
          we = smpl_en_i;
          if (smpl_en_i) begin
            cnt_d = cnt_inc;
            if (cnt_inc == pos_ext) state_d = S_DONE;
          end
        end
        S_DONE: begin
        end
        default: state_d = S_IDLE;
      endcase

      // DEPTH is a power of two, so the natural AW-bit wrap is the ring wrap.
      if (we) waddr_d = waddr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      en_q    <= '0;
      taddr_q <= '0;
      tsrc_q  <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      en_q    <= en_d;
      taddr_q <= taddr_d;
      tsrc_q  <= tsrc_d;
    end
  end

  assign we_o           = we;
  assign waddr_o        = waddr_q;
  assign armed_o        = (state_q == S_ARMED);
  assign triggered_o    = (state_q == S_POST) || (state_q == S_DONE);
  assign capture_done_o = (state_q == S_DONE);
  assign trig_addr_o    = taddr_q;
  assign trig_src_o     = tsrc_q;

endmodule

// File: tb/tb_trig_capture_ctrl.sv
module tb_trig_capture_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm_i, clr_done_i, smpl_en_i;
  logic [AW-1:0] trig_pos_i;
  logic [2:0]    trig_en_i;
  logic          ch_trig_i, uart_trig_i, spi_trig_i, force_trig_i;
  logic          we_o;
  logic [AW-1:0] waddr_o;
  logic          armed_o, triggered_o, capture_done_o;
  logic [AW-1:0] trig_addr_o;
  logic [1:0]    trig_src_o;

  int n_pass = 0;
  int n_chk  = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] m_addr;

  always #5 clk = ~clk;

  trig_capture_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .arm_i          (arm_i),
    .clr_done_i     (clr_done_i),
    .smpl_en_i      (smpl_en_i),
    .trig_pos_i     (trig_pos_i),
    .trig_en_i      (trig_en_i),
    .ch_trig_i      (ch_trig_i),
    .uart_trig_i    (uart_trig_i),
    .spi_trig_i     (spi_trig_i),
    .force_trig_i   (force_trig_i),
    .we_o           (we_o),
    .waddr_o        (waddr_o),
    .armed_o        (armed_o),
    .triggered_o    (triggered_o),
    .capture_done_o (capture_done_o),
    .trig_addr_o    (trig_addr_o),
    .trig_src_o     (trig_src_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // One clock cycle: drive strobe, push the expected write address when a
  // write is predicted, compare on the falling edge, drop pulses after the edge.
  task automatic tick(input logic smpl, input logic expw);
    logic [AW-1:0] e;
    smpl_en_i = smpl;
    if (expw) begin
      exp_q.push_back(m_addr);
      m_addr = m_addr + 3'd1;
    end
    @(negedge clk);
    chk("we", we_o, expw);
    if (we_o === 1'b1) begin
      chk("sb_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("waddr_write", waddr_o, e);
      end
    end
    @(posedge clk);
    #1;
    arm_i = 0; clr_done_i = 0; smpl_en_i = 0;
    ch_trig_i = 0; uart_trig_i = 0; spi_trig_i = 0; force_trig_i = 0;
  endtask

  task automatic do_arm(input logic [AW-1:0] pos, input logic [2:0] en);
    arm_i = 1; trig_pos_i = pos; trig_en_i = en;
    m_addr = '0;
    tick(1'b0, 1'b0);
    chk("arm_waddr0", waddr_o, 0);
    chk("arm_not_armed", armed_o, 0);
  endtask

  initial begin
    rst_n = 0;
    arm_i = 0; clr_done_i = 0; smpl_en_i = 0;
    trig_pos_i = '0; trig_en_i = '0;
    ch_trig_i = 0; uart_trig_i = 0; spi_trig_i = 0; force_trig_i = 0;
    m_addr = '0;
    #12;
    chk("rst_we", we_o, 0);
    chk("rst_waddr", waddr_o, 0);
    chk("rst_armed", armed_o, 0);
    chk("rst_triggered", triggered_o, 0);
    chk("rst_done", capture_done_o, 0);
    chk("rst_trig_addr", trig_addr_o, 0);
    chk("rst_trig_src", trig_src_o, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Basic capture: pos=3, ch enabled, strobe every cycle.
    do_arm(3'd3, 3'b001);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1);
      if (i == 3) chk("t1_not_armed_yet", armed_o, 0);
    end
    chk("t1_armed", armed_o, 1);
    chk("t1_waddr5", waddr_o, 5);
    tick(1'b1, 1'b1);
    ch_trig_i = 1;
    tick(1'b1, 1'b1);
    chk("t1_triggered", triggered_o, 1);
    chk("t1_armed_fell", armed_o, 0);
    chk("t1_trig_addr", trig_addr_o, 6);
    chk("t1_trig_src", trig_src_o, 1);
    tick(1'b1, 1'b1);
    chk("t1_not_done", capture_done_o, 0);
    tick(1'b1, 1'b1);
    chk("t1_done", capture_done_o, 1);
    chk("t1_done_waddr", waddr_o, 1);
    tick(1'b1, 1'b0);
    chk("t1_done_frozen", waddr_o, 1);
    clr_done_i = 1;
    tick(1'b0, 1'b0);
    chk("t1_clr_done", capture_done_o, 0);
    chk("t1_clr_trig", triggered_o, 0);
    chk("t1_keep_taddr", trig_addr_o, 6);

    // Disabled spi ignored, force accepted.
    do_arm(3'd2, 3'b011);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
    chk("t2_armed", armed_o, 1);
    spi_trig_i = 1;
    tick(1'b1, 1'b1);
    chk("t2_spi_ignored", armed_o, 1);
    chk("t2_spi_not_trig", triggered_o, 0);
    force_trig_i = 1;
    tick(1'b1, 1'b1);
    chk("t2_force_src", trig_src_o, 0);
    chk("t2_force_addr", trig_addr_o, 7);
    chk("t2_triggered", triggered_o, 1);
    tick(1'b1, 1'b1);
    chk("t2_done", capture_done_o, 1);
    chk("t2_done_waddr", waddr_o, 1);
    clr_done_i = 1;
    tick(1'b0, 1'b0);

    // Simultaneous ch/uart/spi: ch wins.
    do_arm(3'd1, 3'b111);
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1);
    chk("t3_armed", armed_o, 1);
    ch_trig_i = 1; uart_trig_i = 1; spi_trig_i = 1;
    tick(1'b0, 1'b0);
    chk("t3_src_ch", trig_src_o, 1);
    chk("t3_addr", trig_addr_o, 7);
    chk("t3_post", triggered_o, 1);
    chk("t3_not_done", capture_done_o, 0);
    tick(1'b1, 1'b1);
    chk("t3_done", capture_done_o, 1);
    chk("t3_done_waddr", waddr_o, 0);
    clr_done_i = 1;
    tick(1'b0, 1'b0);

    // pos=0; spi pulse in PRETRIG is lost.
    do_arm(3'd0, 3'b100);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) spi_trig_i = 1;
      tick(1'b1, 1'b1);
      if (i == 2) begin
        chk("t4_pretrig_spi_trig", triggered_o, 0);
        chk("t4_pretrig_spi_armed", armed_o, 0);
      end
    end
    chk("t4_armed", armed_o, 1);
    chk("t4_armed_waddr", waddr_o, 0);
    spi_trig_i = 1;
    tick(1'b1, 1'b1);
    chk("t4_done", capture_done_o, 1);
    chk("t4_src_spi", trig_src_o, 3);
    chk("t4_taddr", trig_addr_o, 0);
    chk("t4_waddr", waddr_o, 1);
    clr_done_i = 1;
    tick(1'b0, 1'b0);

    // clr_done mid-POST, then arm+clr together.
    do_arm(3'd3, 3'b001);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    ch_trig_i = 1;
    tick(1'b1, 1'b1);
    chk("t5_post", triggered_o, 1);
    clr_done_i = 1;
    tick(1'b1, 1'b0);
    chk("t5_idle_trig", triggered_o, 0);
    chk("t5_idle_armed", armed_o, 0);
    chk("t5_keep_taddr", trig_addr_o, 5);
    chk("t5_keep_src", trig_src_o, 1);
    chk("t5_waddr_hold", waddr_o, 6);
    arm_i = 1; clr_done_i = 1; trig_pos_i = 3'd3; trig_en_i = 3'b001;
    tick(1'b0, 1'b0);
    chk("t5_arm_clr_idle", armed_o, 0);
    chk("t5_arm_clr_waddr", waddr_o, 6);
    tick(1'b1, 1'b0);

    // Asynchronous reset mid-ARMED.
    do_arm(3'd6, 3'b001);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    chk("t6_armed", armed_o, 1);
    smpl_en_i = 1;
    #2;
    rst_n = 0;
    #1;
    chk("t6_rst_we", we_o, 0);
    chk("t6_rst_waddr", waddr_o, 0);
    chk("t6_rst_armed", armed_o, 0);
    chk("t6_rst_trig", triggered_o, 0);
    chk("t6_rst_done", capture_done_o, 0);
    chk("t6_rst_taddr", trig_addr_o, 0);
    chk("t6_rst_src", trig_src_o, 0);
    smpl_en_i = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    // Sparse strobes (every 3rd cycle), pos=7.
    do_arm(3'd7, 3'b001);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("t7_not_armed", armed_o, 0);
    tick(1'b1, 1'b1);
    chk("t7_armed", armed_o, 1);
    chk("t7_waddr", waddr_o, 1);
    ch_trig_i = 1;
    tick(1'b0, 1'b0);
    chk("t7_post", triggered_o, 1);
    chk("t7_taddr", trig_addr_o, 1);
    for (int k = 0; k < 7; k++) begin
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b1);
      if (k == 5) chk("t7_not_done", capture_done_o, 0);
    end
    chk("t7_done", capture_done_o, 1);
    chk("t7_done_waddr", waddr_o, 0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("t7_frozen", waddr_o, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/trig_capture_ctrl.md
# trig_capture_ctrl

Capture sequencer for the logic-analyzer front end. It arms the sample buffer, fills a pre-trigger window, and picks the first enabled trigger among the channel, UART and SPI trigger units (SPI side: the `SPItrig` pulse from the SPI receiver/matcher) or a forced trigger. It then counts the post-trigger samples and flags capture done. It sits between the command processor (arm, config, clear) and the sample RAM write port.

## Interface

- DEPTH, 512, sample RAM depth in entries; power of 2, at least 4
- AW, $clog2(DEPTH), RAM address width

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- arm  in  1  one-cycle pulse from the command processor; starts a capture
- clr_done  in  1  one-cycle pulse; returns to IDLE from any state (aborts a capture)
- smpl_en  in  1  sample strobe from the decimator; one RAM write per strobe while capturing
- trig_pos  in  AW  number of post-trigger samples, 0..DEPTH-1; latched on accepted `arm`
- trig_en  in  3  trigger source enables {spi, uart, ch}; latched on accepted `arm`
- ch_trig  in  1  channel trigger pulse
- uart_trig  in  1  UART match trigger pulse
- spi_trig  in  1  SPI match trigger pulse
- force_trig  in  1  forced trigger; always enabled
- we  out  1  RAM write enable (combinational)
- waddr  out  AW  RAM write address (registered)
- armed  out  1  high in ARMED
- triggered  out  1  high in POST and DONE
- capture_done  out  1  high in DONE
- trig_addr  out  AW  value of `waddr` on the trigger-accept cycle; held until next accepted `arm`
- trig_src  out  2  source of the accepted trigger: 0 force, 1 ch, 2 uart, 3 spi

## Operation

- States: IDLE, PRETRIG, ARMED, POST, DONE.
- **IDLE**
  - `arm` goes to PRETRIG.
  - On that same edge: `waddr` is cleared to 0, the pre-trigger counter is cleared, and `trig_pos` and `trig_en` are latched.
- **PRETRIG**
  - Each `smpl_en` writes one sample and increments the pre-trigger counter.
  - When the count reaches DEPTH − trig_pos_lat (counting the current strobe), the next state is ARMED.
  - All triggers, including force, are ignored in PRETRIG.
- **ARMED**
  - Writes continue.
  - hit = force_trig | (ch_trig & en[0]) | (uart_trig & en[1]) | (spi_trig & en[2]).
  - On hit: go to POST, latch trig_addr = waddr, and latch trig_src.
  - Priority when several sources fire together: force > ch > uart > spi.
- **POST**
  - Each `smpl_en` increments the post counter.
  - When the count reaches trig_pos_lat, the next state is DONE.
  - If `smpl_en` is high on the trigger-accept cycle, that sample is post sample #1 and is written at trig_addr.
  - If trig_pos_lat = 0, ARMED goes directly to DONE on hit; no post samples are written beyond the trigger cycle's own write.
- **DONE**
  - `we` = 0 and `waddr` is frozen.
  - Waits for `clr_done`, then goes to IDLE.
- `we` = smpl_en & (state ∈ {PRETRIG, ARMED, POST}).
- `waddr` increments on every cycle where `we` is high and wraps DEPTH−1 → 0.
- `arm` outside IDLE is ignored. `clr_done` wins over `arm` on the same cycle.
- `clr_done` in any state: next state IDLE, `we` forced to 0 that cycle. `trig_addr` and `trig_src` are kept.
- Counters are AW+1 bits wide; no overflow is possible.

## Timing

- Reset values: state IDLE; `we`, `armed`, `triggered` and `capture_done` all 0; `waddr`, `trig_addr` and `trig_src` all 0.
- Reset is asynchronous. Asserting it mid-capture drops straight to IDLE with all outputs at their reset values.
- `arm` → `waddr` = 0 and state PRETRIG visible on the next cycle.
- The trigger-accept edge moves the state to POST. `triggered` rises on the cycle after the hit.
- The final post sample is written on its strobe cycle. `capture_done` rises on the following cycle.
- `armed` falls on the same edge that `triggered` rises.
- Trigger inputs are single-cycle pulses, sampled every cycle while in ARMED. A pulse in PRETRIG is lost; it is not queued.
- After DONE, the oldest sample sits at waddr (wrapped). Exactly DEPTH samples have been written.

## Test plan

- DEPTH=8, trig_pos=3, trig_en=3'b001, `smpl_en` every cycle, `arm`:
  - 5 writes to addr 0..4, then `armed`=1.
  - `ch_trig` at addr 6 → `trig_addr`=6, `trig_src`=1.
  - Writes to 6, 7, 0, then `capture_done`=1 with `waddr`=1.
- `spi_trig` with trig_en=3'b011 → ignored, stays ARMED. `force_trig` → `trig_src`=0, POST.
- `ch_trig`, `uart_trig` and `spi_trig` all pulse on the same cycle, trig_en=3'b111 → `trig_src`=1.
- trig_pos=0: a hit in ARMED goes to DONE on the next cycle. `spi_trig` pulsed during PRETRIG has no effect.
- Abort and reset:
  - `clr_done` mid-POST → IDLE next cycle, `we`=0.
  - `arm` together with `clr_done` → stays IDLE.
  - `rst_n` low mid-ARMED → all outputs 0 immediately.
- `smpl_en` every 3rd cycle, DEPTH=8, trig_pos=7:
  - `armed` rises only after 1 strobe.
  - `capture_done` rises after 7 post strobes; no write occurs in DONE.
